// File: rtl/hash_state_serializer.sv
// hash_state_serializer
//   Parallel-load, word-serial unloader for SHA working state. A load captures
//   DEPTH words of WIDTH bits in one cycle. The words leave one per accepted
//   beat on a valid/ready stream, starting with word 0 (a).
//   Optional feature macro: HASH_SERIALIZER_REPLAY_EN. When it is defined, the
//   tail refills with the departing head word, so the load rotates back into
//   place after a drain. It also adds the replay_i input, which re-emits the
//   last load.
module hash_state_serializer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [DEPTH*WIDTH-1:0] load_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_data_o,
  output logic                   out_last_o,
  output logic [CW-1:0]          words_left_o,
`ifdef HASH_SERIALIZER_REPLAY_EN
  input  logic                   replay_i,
`endif
  output logic                   busy_o
);

  // The state is not stored separately; it is derived from the word counter.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [WIDTH-1:0] word_reg  [DEPTH];
  logic [WIDTH-1:0] word_next [DEPTH];
  logic [WIDTH-1:0] shift_src [DEPTH];
  logic [CW-1:0]    words_left_reg;
  logic [CW-1:0]    words_left_next;
  logic [0:0]       state;
  logic             is_idle;
  logic             is_shift;
  logic             is_last;
  logic             beat_fire;
  logic             load_fire;
  logic             replay_fire;
  logic [WIDTH-1:0] tail_fill;

  assign state    = (words_left_reg == '0) ? ST_IDLE : ST_SHIFT;
  assign is_idle  = (state == ST_IDLE);
  assign is_shift = (state == ST_SHIFT);
  assign is_last  = (words_left_reg == CW'(1));

  // A beat leaves on valid & ready. A new load may land only when idle,
  // or during the final beat so that there is no bubble between loads.
  assign beat_fire    = is_shift & out_ready_i;
  assign load_ready_o = is_idle | (beat_fire & is_last);
  assign load_fire    = load_valid_i & load_ready_o;

`ifdef HASH_SERIALIZER_REPLAY_EN
  // The head rotates into the tail, so the original load is back in place
  // after a full drain. A load takes priority over a replay.
  assign tail_fill   = word_reg[0];
  assign replay_fire = is_idle & replay_i & ~load_fire;
`else
  assign tail_fill   = '0;
  assign replay_fire = 1'b0;
`endif

  // Each word either loads, shifts one place toward the head, or holds.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    if (gi == DEPTH - 1) begin : g_tail
      assign shift_src[gi] = tail_fill;
    end else begin : g_body
      assign shift_src[gi] = word_reg[gi+1];
    end
    assign word_next[gi] = load_fire ? load_data_i[gi*WIDTH +: WIDTH] :
                           beat_fire ? shift_src[gi] : word_reg[gi];
  end

  // Counter of words still owed downstream, including the head word.
  always_comb begin
    words_left_next = words_left_reg;
    if (load_fire || replay_fire) begin
      words_left_next = CW'(DEPTH);
    end else if (beat_fire) begin
      words_left_next = words_left_reg - CW'(1);
    end
  end

  // Word storage; reset clears every word so the idle head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) word_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) word_reg[i] <= word_next[i];
    end
  end

  // Counter register; reset discards any words still in flight.
  always_ff @(posedge clk) begin
    if (rst) words_left_reg <= '0;
    else     words_left_reg <= words_left_next;
  end

  assign out_valid_o  = is_shift;
  assign busy_o       = is_shift;
  assign out_data_o   = word_reg[0];
  assign out_last_o   = is_last;
  assign words_left_o = words_left_reg;

endmodule

// File: tb/tb_hash_state_serializer.sv
// Testbench for hash_state_serializer: directed scenarios followed by random
// traffic. Each scenario is checked every cycle against a queue-based model.
module tb_hash_state_serializer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   load_valid = 1'b0;
  logic                   load_ready;
  logic [DEPTH*WIDTH-1:0] load_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic [CW-1:0]          words_left;
  logic                   busy;
`ifdef HASH_SERIALIZER_REPLAY_EN
  logic                   replay = 1'b0;
`endif

  hash_state_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_data_i  (load_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .words_left_o (words_left),
`ifdef HASH_SERIALIZER_REPLAY_EN
    .replay_i     (replay),
`endif
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  bit verbose = 1'b1;

  // Reference model: words still owed, the last loaded block, and the idle head.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] saved [DEPTH];
  logic [WIDTH-1:0] idle_head = '0;
  bit               known = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the coming rising edge.
  task automatic do_cycle(input bit r, input bit lv, input logic [DEPTH*WIDTH-1:0] d,
                          input bit rdy, input bit rp);
    bit mready, lfire, bfire;
    int n;
    @(negedge clk);
    rst = r; load_valid = lv; load_data = d; out_ready = rdy;
`ifdef HASH_SERIALIZER_REPLAY_EN
    replay = rp;
`endif
    #1;
    n = exp_q.size();
    mready = (n == 0) || (rdy && n == 1);
    if (known) begin
      check("out_valid", 64'(out_valid), 64'(n != 0));
      check("busy", 64'(busy), 64'(n != 0));
      check("words_left", 64'(words_left), 64'(n));
      check("out_last", 64'(out_last), 64'(n == 1));
      check("load_ready", 64'(load_ready), 64'(mready));
      check("out_data", 64'(out_data), 64'((n != 0) ? exp_q[0] : idle_head));
    end
    if (r) begin
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++) saved[k] = '0;
      idle_head = '0;
      known = 1'b1;
    end else begin
      lfire = lv && mready;
      bfire = (n != 0) && rdy;
      if (bfire && verbose)
        $display("[TB] beat word=%h left=%0d", exp_q[0], n);
      if (lfire) begin
        if (verbose) $display("[TB] load accepted word0=%h", d[WIDTH-1:0]);
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
          saved[k] = d[k*WIDTH +: WIDTH];
          exp_q.push_back(saved[k]);
        end
      end else if (bfire) begin
        void'(exp_q.pop_front());
`ifdef HASH_SERIALIZER_REPLAY_EN
        if (exp_q.size() == 0) idle_head = saved[0];
`else
        if (exp_q.size() == 0) idle_head = '0;
`endif
      end
`ifdef HASH_SERIALIZER_REPLAY_EN
      else if (n == 0 && rp) begin
        if (verbose) $display("[TB] replay accepted");
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(saved[k]);
      end
`endif
    end
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] rand_block();
    logic [DEPTH*WIDTH-1:0] b;
    for (int k = 0; k < DEPTH; k++) b[k*WIDTH +: WIDTH] = $urandom;
    return b;
  endfunction

  logic [DEPTH*WIDTH-1:0] sha_blk;
  logic [DEPTH*WIDTH-1:0] blk2;
  bit                     bp_pat [4];

  initial begin
    sha_blk[0*32 +: 32] = 32'h6a09e667;
    sha_blk[1*32 +: 32] = 32'hbb67ae85;
    sha_blk[2*32 +: 32] = 32'h3c6ef372;
    sha_blk[3*32 +: 32] = 32'ha54ff53a;
    sha_blk[4*32 +: 32] = 32'h510e527f;
    sha_blk[5*32 +: 32] = 32'h9b05688c;
    sha_blk[6*32 +: 32] = 32'h1f83d9ab;
    sha_blk[7*32 +: 32] = 32'h5be0cd19;
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;

    // Reset held for two cycles.
    do_cycle(1, 0, '0, 0, 0);
    do_cycle(1, 0, '0, 0, 0);
    do_cycle(0, 0, '0, 0, 0);

    // SHA initial state, drained at full rate.
    do_cycle(0, 1, sha_blk, 1, 0);
    for (int i = 0; i < 10; i++) do_cycle(0, 0, '0, 1, 0);

    // Back-pressure pattern 1,0,0,1,...
    do_cycle(0, 1, sha_blk, 0, 0);
    for (int i = 0; i < 30; i++) do_cycle(0, 0, '0, bp_pat[i % 4], 0);

    // Back-to-back: a second load is held throughout the first drain.
    do_cycle(0, 1, sha_blk, 1, 0);
    blk2 = rand_block();
    for (int i = 0; i < 9; i++) do_cycle(0, 1, blk2, 1, 0);
    for (int i = 0; i < 9; i++) do_cycle(0, 0, '0, 1, 0);

    // Reset after three beats.
    do_cycle(0, 1, rand_block(), 1, 0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, '0, 1, 0);
    do_cycle(1, 0, '0, 1, 0);
    do_cycle(0, 0, '0, 1, 0);
    do_cycle(0, 0, '0, 1, 0);

`ifdef HASH_SERIALIZER_REPLAY_EN
    // Replay after a drain, then replay and load together (load wins).
    do_cycle(0, 1, sha_blk, 1, 0);
    for (int i = 0; i < 9; i++) do_cycle(0, 0, '0, 1, 0);
    do_cycle(0, 0, '0, 1, 1);
    for (int i = 0; i < 9; i++) do_cycle(0, 0, '0, 1, 0);
    do_cycle(0, 1, rand_block(), 1, 1);
    for (int i = 0; i < 9; i++) do_cycle(0, 0, '0, 1, 0);
`endif

    // Random traffic.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++)
      do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30, rand_block(),
               $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
